// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV-M multiply/divide unit: func3 op codes,
// FSM state encoding and operand-classification helpers.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step on {acc,lo} or
// restoring-divide step on {rem,quot}, both operating on unsigned magnitudes.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            div_mode_i,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] mag_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            fits;

  always_comb begin
    // Multiplier bits are consumed LSB first; the carry shifts back into acc.
    add_sum = {1'b0, acc_i} + (lo_i[0] ? {1'b0, mag_i} : {(XLEN+1){1'b0}});
    shifted = {acc_i, lo_i[XLEN-1]};
    fits    = (shifted >= {1'b0, mag_i});
    diff    = shifted[XLEN-1:0] - mag_i;
    acc_o   = add_sum[XLEN:1];
    lo_o    = {add_sum[0], lo_i[XLEN-1:1]};
    if (div_mode_i) begin
      acc_o = fits ? diff : shifted[XLEN-1:0];
      lo_o  = {lo_i[XLEN-2:0], fits};
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: one product/quotient bit per cycle,
// valid/ready handshake on both sides, tag pass-through and flush.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         op_q;
  logic [TAG_W-1:0]   tag_q;
  logic [XLEN-1:0]    acc_q;
  logic [XLEN-1:0]    lo_q;
  logic [XLEN-1:0]    mag_q;
  logic               neg_q;
  logic               neg_rem_q;
  logic [XLEN-1:0]    result_q;
  logic [TAG_W-1:0]   out_tag_q;

  logic               a_neg, b_neg;
  logic [XLEN-1:0]    mag_a, mag_b;
  logic               div_zero, div_ovf;
  logic [XLEN-1:0]    early_res;
  logic [XLEN-1:0]    step_acc, step_lo;
  logic [2*XLEN-1:0]  prod, prod_s;
  logic [XLEN-1:0]    quot_s, rem_s, fix_res;

  assign in_ready   = (state_q == ST_IDLE) & ~flush & ~rst;
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign out_result = result_q;
  assign out_tag    = out_tag_q;

  // Accept-time operand decode and early-out detection.
  always_comb begin
    a_neg     = is_signed_a(in_op) & in_a[XLEN-1];
    b_neg     = is_signed_b(in_op) & in_b[XLEN-1];
    mag_a     = a_neg ? (~in_a + 1'b1) : in_a;
    mag_b     = b_neg ? (~in_b + 1'b1) : in_b;
    div_zero  = is_div(in_op) && (in_b == '0);
    div_ovf   = ((in_op == MD_DIV) || (in_op == MD_REM)) && (in_a == INT_MIN) && (in_b == ALL_ONES);
    early_res = is_rem(in_op) ? (div_zero ? in_a : '0) : (div_zero ? ALL_ONES : in_a);
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .div_mode_i (is_div(op_q)),
    .acc_i      (acc_q),
    .lo_i       (lo_q),
    .mag_i      (mag_q),
    .acc_o      (step_acc),
    .lo_o       (step_lo)
  );

  // Sign correction and result selection applied in FIX.
  always_comb begin
    prod   = {acc_q, lo_q};
    prod_s = neg_q ? (~prod + 1'b1) : prod;
    quot_s = neg_q ? (~lo_q + 1'b1) : lo_q;
    rem_s  = neg_rem_q ? (~acc_q + 1'b1) : acc_q;
    case (op_q)
      MD_MUL:                       fix_res = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fix_res = quot_s;
      default:                      fix_res = rem_s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      result_q  <= '0;
      out_tag_q <= '0;
    end else if (flush) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q      <= in_op;
            tag_q     <= in_tag;
            cnt_q     <= '0;
            acc_q     <= '0;
            lo_q      <= mag_a;
            mag_q     <= mag_b;
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (div_zero || div_ovf) begin
              result_q  <= early_res;
              out_tag_q <= in_tag;
              state_q   <= ST_DONE;
            end else begin
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc_q <= step_acc;
          lo_q  <= step_lo;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_FIX;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_FIX: begin
          result_q  <= fix_res;
          out_tag_q <= tag_q;
          state_q   <= ST_DONE;
        end
        default: begin
          if (out_ready) state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter (XLEN=32): directed vectors, early-outs,
// randomized ops against an arithmetic reference, backpressure, flush and reset.
module tb_muldiv_iter;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, out_ready;
  logic             in_ready, out_valid, busy;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a, in_b, out_result;
  logic [TAG_W-1:0] in_tag, out_tag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 3'd4 && b == 32'd0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 2;
  endfunction

  // Issues one request and returns what appears on the output; latency counts
  // cycles from the accepting edge (1 = valid right after that edge).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, output logic [31:0] res,
                        output logic [TAG_W-1:0] tg, output int lat, output bit timed_out);
    int guard;
    timed_out = 1'b0;
    res = '0;
    tg  = '0;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid || guard >= 200) timed_out = 1'b1;
    res = out_result;
    tg  = out_tag;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'd3; in_b = 32'd4; in_tag = 5'd9;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (out_result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", out_result); end
    n_checks++; if (out_tag !== 5'd0) begin n_fail++; $display("FAIL reset_tag: got %h expected 0", out_tag); end
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [2:0]  ops  [0:13] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                 3'd4, 3'd7, 3'd4, 3'd6, 3'd5, 3'd6};
    logic [31:0] as   [0:13] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
                                 32'd1234, 32'hFFFF_FFF9};
    logic [31:0] bs   [0:13] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'd2, 32'd2, 32'd7, 32'd7,
                                 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'd0, 32'd0};
    logic [31:0] exps [0:13] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0,
                                 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    int          lats [0:13] = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1, 1, 1};
    logic [31:0] res;
    logic [TAG_W-1:0] tg, tag;
    int lat;
    bit to;
    for (int i = 0; i < 14; i++) begin
      tag = (i == 0) ? 5'd3 : TAG_W'(i + 7);
      run_op(ops[i], as[i], bs[i], tag, res, tg, lat, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL directed_timeout[%0d]: no out_valid within bound", i); end
      n_checks++; if (res !== exps[i]) begin n_fail++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, exps[i]); end
      n_checks++; if (tg !== tag) begin n_fail++; $display("FAIL directed_tag[%0d]: got %h expected %h", i, tg, tag); end
      n_checks++; if (lat !== lats[i]) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, lats[i]); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, res, exp_res;
    logic [TAG_W-1:0] tag, tg;
    int lat, sel;
    bit to;
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      tag = TAG_W'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      exp_res = ref_result(op, a, b);
      run_op(op, a, b, tag, res, tg, lat, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL random_timeout[%0d]: no out_valid within bound", i); end
      n_checks++; if (res !== exp_res) begin n_fail++; $display("FAIL random_result[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, res, exp_res); end
      n_checks++; if (tg !== tag) begin n_fail++; $display("FAIL random_tag[%0d]: got %h expected %h", i, tg, tag); end
      n_checks++; if (lat !== ref_latency(op, a, b)) begin n_fail++; $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, ref_latency(op, a, b)); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    logic [TAG_W-1:0] tg;
    int lat;
    bit to;
    out_ready = 1'b0;
    run_op(3'd5, 32'd100, 32'd7, 5'd17, res, tg, lat, to);
    n_checks++; if (to || res !== 32'd14) begin n_fail++; $display("FAIL bp_first_result: got %h expected %h", res, 32'd14); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, out_valid); end
      n_checks++; if (out_result !== 32'd14) begin n_fail++; $display("FAIL bp_hold_result[%0d]: got %h expected %h", i, out_result, 32'd14); end
      n_checks++; if (out_tag !== 5'd17) begin n_fail++; $display("FAIL bp_hold_tag[%0d]: got %h expected %h", i, out_tag, 5'd17); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_in_ready[%0d]: got %b expected 0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 5'd18, res, tg, lat, to);
    n_checks++; if (to || res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL bp_next_result: got %h expected %h", res, 32'hFFFF_FFFF); end
    n_checks++; if (tg !== 5'd18) begin n_fail++; $display("FAIL bp_next_tag: got %h expected %h", tg, 5'd18); end
  endtask

  task automatic test_flush();
    bit seen;
    in_op = 3'd0; in_a = 32'd11; in_b = 32'd13; in_tag = 5'd21; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_calc_busy: got %b expected 0", busy); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_calc_no_valid: got %b expected 0", seen); end
    // in_valid coincident with flush must be ignored
    flush = 1'b1; in_valid = 1'b1; in_op = 3'd0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_accept_blocked: got busy %b expected 0", busy); end
    // flush while holding a result discards it even with out_ready high
    out_ready = 1'b0;
    in_op = 3'd4; in_a = 32'd5; in_b = 32'd0; in_tag = 5'd22; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_done_precond: got %b expected 1", out_valid); end
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_done_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_result !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL flush_done_result_kept: got %h expected %h", out_result, 32'hFFFF_FFFF); end
  endtask

  task automatic test_rst_mid();
    logic [31:0] res;
    logic [TAG_W-1:0] tg;
    int lat;
    bit to;
    in_op = 3'd6; in_a = 32'd1000; in_b = 32'd7; in_tag = 5'd25; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    n_checks++; if (out_result !== 32'd0) begin n_fail++; $display("FAIL rst_mid_result: got %h expected 0", out_result); end
    n_checks++; if (out_tag !== 5'd0) begin n_fail++; $display("FAIL rst_mid_tag: got %h expected 0", out_tag); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b expected 0", in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(3'd6, 32'hFFFF_FC18, 32'd7, 5'd26, res, tg, lat, to);
    n_checks++; if (to || res !== ref_result(3'd6, 32'hFFFF_FC18, 32'd7)) begin n_fail++; $display("FAIL rst_mid_next_result: got %h expected %h", res, ref_result(3'd6, 32'hFFFF_FC18, 32'd7)); end
    n_checks++; if (tg !== 5'd26) begin n_fail++; $display("FAIL rst_mid_next_tag: got %h expected %h", tg, 5'd26); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
